// File: rtl/alu_if.sv
// Requester, response and status signals shared between alu_ctrl and its users.
// The slave modport is the controller's view; master is the requester/consumer side.
interface alu_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_x;
  logic [15:0] req0_y;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_x;
  logic [15:0] req1_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, busy
  );

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, busy
  );
endinterface

// File: rtl/alu_ctrl.sv
// Two-requester, single-issue ALU controller with round-robin arbitration and
// iterative 16-cycle multiply / restoring divide.
//
// state | meaning
// IDLE  | waiting for a request; only state that can accept
// EXEC  | single-cycle ops evaluated from the registered operands
// MUL   | shift-add multiply, one bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | response held on rsp_* until rsp_ready
module alu_ctrl (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  state_t      state, state_nxt;
  logic        ptr, grant, accept, both;
  logic [3:0]  in_op, op_r, cnt;
  logic [15:0] in_x, in_y, x_r, y_r, a_r, b_r, p_r, res_r;
  logic        id_r, carry_r;

  logic [15:0] alu_res;
  logic        alu_carry;
  logic [16:0] sum17;
  logic [15:0] fill;
  logic [31:0] sh32;

  logic [15:0] mul_acc_nxt;
  logic [16:0] rem_sh, rem_sub;
  logic [15:0] quo_nxt, rem_nxt;

  assign both   = bus.req0_valid & bus.req1_valid;
  assign grant  = both ? ptr : bus.req1_valid;
  assign accept = (state == IDLE) & (bus.req0_valid | bus.req1_valid);
  assign in_op  = grant ? bus.req1_op : bus.req0_op;
  assign in_x   = grant ? bus.req1_x  : bus.req0_x;
  assign in_y   = grant ? bus.req1_y  : bus.req0_y;

  assign bus.req0_ready = (state == IDLE) & bus.req0_valid & ~grant;
  assign bus.req1_ready = (state == IDLE) & bus.req1_valid & grant;
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_result = res_r;
  assign bus.rsp_zero   = (state == DONE) & (res_r == 16'h0000);
  assign bus.rsp_carry  = carry_r;
  assign bus.rsp_id     = id_r;
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_op == OP_MUL)      state_nxt = MUL;
          else if (in_op == OP_DIV) state_nxt = DIV;
          else                      state_nxt = EXEC;
        end
      end
      EXEC:     state_nxt = DONE;
      MUL, DIV: if (cnt == 4'd0) state_nxt = DONE;
      DONE:     if (bus.rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Single-cycle ops; shifts build a 32-bit {x,fill} word so every fill mode,
  // including rotate, is a plain shift followed by picking one half.
  always_comb begin
    alu_res   = 16'h0000;
    alu_carry = 1'b0;
    sum17     = {1'b0, x_r} + {1'b0, y_r};
    fill      = 16'h0000;
    sh32      = 32'h0;
    if (op_r[3]) begin
      case (op_r[1:0])
        2'b00:   fill = 16'h0000;
        2'b01:   fill = 16'hFFFF;
        2'b10:   fill = {16{op_r[2] ? x_r[15] : x_r[0]}};
        default: fill = x_r;
      endcase
      if (op_r[2]) begin
        sh32    = {fill, x_r} >> y_r[3:0];
        alu_res = sh32[15:0];
      end else begin
        sh32    = {x_r, fill} << y_r[3:0];
        alu_res = sh32[31:16];
      end
    end else begin
      case (op_r[2:0])
        3'b000: {alu_carry, alu_res} = sum17;
        3'b001: begin
          alu_res   = x_r - y_r;
          alu_carry = (x_r < y_r);
        end
        3'b100:  alu_res = x_r & y_r;
        3'b101:  alu_res = x_r | y_r;
        3'b110:  alu_res = x_r ^ y_r;
        default: alu_res = 16'h0000;
      endcase
    end
  end

  // a_r holds multiplier / dividend-then-quotient, b_r multiplicand / divisor,
  // p_r the partial product / partial remainder.
  always_comb begin
    mul_acc_nxt = p_r + (a_r[0] ? b_r : 16'h0000);
    rem_sh      = {p_r, a_r[15]};
    rem_sub     = rem_sh - {1'b0, b_r};
    if (!rem_sub[16]) begin
      rem_nxt = rem_sub[15:0];
      quo_nxt = {a_r[14:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[15:0];
      quo_nxt = {a_r[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= 1'b0;
      op_r    <= 4'h0;
      x_r     <= 16'h0000;
      y_r     <= 16'h0000;
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      p_r     <= 16'h0000;
      res_r   <= 16'h0000;
      cnt     <= 4'h0;
      id_r    <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= in_op;
            x_r  <= in_x;
            y_r  <= in_y;
            id_r <= grant;
            cnt  <= 4'd15;
            p_r  <= 16'h0000;
            if (in_op == OP_DIV) begin
              a_r <= in_x;
              b_r <= in_y;
            end else begin
              a_r <= in_y;
              b_r <= in_x;
            end
            if (both) ptr <= ~grant;
          end
        end
        EXEC: begin
          res_r   <= alu_res;
          carry_r <= alu_carry;
        end
        MUL: begin
          p_r <= mul_acc_nxt;
          a_r <= {1'b0, a_r[15:1]};
          b_r <= {b_r[14:0], 1'b0};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            res_r   <= mul_acc_nxt;
            carry_r <= 1'b0;
          end
        end
        DIV: begin
          p_r <= rem_nxt;
          a_r <= quo_nxt;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            res_r   <= (y_r == 16'h0000) ? 16'hFFFF : quo_nxt;
            carry_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_alu_ctrl;
  logic clk = 1'b0;
  logic reset;
  alu_if bus ();

  alu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: idle / counting down to response / response held.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_res  = 16'h0;
  bit          m_carry = 1'b0;
  bit          m_id   = 1'b0;
  bit          m_ptr  = 1'b0;

  bit rec = 1'b0;
  int gq[$];
  int iq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] r, output logic c);
    logic [16:0] s;
    logic [31:0] p;
    logic        fb;
    int          n;
    r = 16'h0;
    c = 1'b0;
    case (op)
      4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16]; end
      4'd1: begin r = x - y; c = (x < y); end
      4'd2: begin p = {16'h0, x} * {16'h0, y}; r = p[15:0]; end
      4'd3: r = (y == 16'h0) ? 16'hFFFF : x / y;
      4'd4: r = x & y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7: r = 16'h0;
      default: begin
        n = int'(y[3:0]);
        r = x;
        for (int i = 0; i < n; i++) begin
          case (op[1:0])
            2'd0:    fb = 1'b0;
            2'd1:    fb = 1'b1;
            2'd2:    fb = op[2] ? x[15] : x[0];
            default: fb = op[2] ? r[0] : r[15];
          endcase
          if (op[2]) r = {fb, r[15:1]};
          else       r = {r[14:0], fb};
        end
      end
    endcase
  endfunction

  task automatic compare();
    bit idle, v0, v1, g;
    v0   = bus.req0_valid;
    v1   = bus.req1_valid;
    idle = !(m_busy || m_done);
    g    = (v0 && v1) ? m_ptr : v1;
    chk("req0_ready", bus.req0_ready, idle & v0 & !g);
    chk("req1_ready", bus.req1_ready, idle & v1 & g);
    chk("busy", bus.busy, !idle);
    chk("rsp_valid", bus.rsp_valid, m_done);
    if (m_done) begin
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_zero", bus.rsp_zero, m_res == 16'h0);
      chk("rsp_carry", bus.rsp_carry, m_carry);
      chk("rsp_id", bus.rsp_id, m_id);
    end
  endtask

  task automatic model_update();
    bit          v0, v1, g;
    logic [3:0]  op;
    logic [15:0] x, y, r;
    logic        c;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ptr  = 1'b0;
    end else if (m_done) begin
      if (bus.rsp_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (v0 || v1) begin
      g = (v0 && v1) ? m_ptr : v1;
      if (v0 && v1) m_ptr = !g;
      op = g ? bus.req1_op : bus.req0_op;
      x  = g ? bus.req1_x  : bus.req0_x;
      y  = g ? bus.req1_y  : bus.req0_y;
      ref_op(op, x, y, r, c);
      m_res   = r;
      m_carry = c;
      m_id    = g;
      m_cnt   = (op == 4'd2 || op == 4'd3) ? 16 : 1;
      m_busy  = 1'b1;
    end
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    #1;
    compare();
    if (rec) begin
      if (bus.req0_ready) gq.push_back(0);
      if (bus.req1_ready) gq.push_back(1);
      if (bus.rsp_valid && bus.rsp_ready) iq.push_back(int'(bus.rsp_id));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit v0, input bit v1, input logic [3:0] op,
                       input logic [15:0] x, input logic [15:0] y);
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_op = op;  bus.req1_op = op;
    bus.req0_x  = x;   bus.req1_x  = x;
    bus.req0_y  = y;   bus.req1_y  = y;
  endtask

  task automatic run_op(input bit id, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input bit ez, input bit ec, input int elat);
    int edges;
    drive(!id, id, op, x, y);
    bus.rsp_ready = 1'b1;
    #1;
    chk("accept_ready", id ? bus.req1_ready : bus.req0_ready, 1);
    step();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    edges = 1;
    while (!bus.rsp_valid && edges < 40) begin
      step();
      edges++;
    end
    chk("latency", edges, elat);
    chk("lit_result", bus.rsp_result, er);
    chk("lit_zero", bus.rsp_zero, ez);
    chk("lit_carry", bus.rsp_carry, ec);
    chk("lit_id", bus.rsp_id, id);
    step();
  endtask

  initial begin
    int  n;
    bit  seen;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_carry", bus.rsp_carry, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    reset = 1'b0;
    step();

    run_op(1'b0, 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2);
    run_op(1'b1, 4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 2);
    run_op(1'b0, 4'b0010, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 17);
    run_op(1'b1, 4'b0011, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 17);
    run_op(1'b0, 4'b0011, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 17);
    run_op(1'b0, 4'b1011, 16'h8001, 16'h0001, 16'h0003, 1'b0, 1'b0, 2);

    // Backpressure: response held five cycles with both requesters waiting.
    drive(1'b1, 1'b0, 4'b1110, 16'h8000, 16'h0004);
    bus.rsp_ready = 1'b0;
    step();
    drive(1'b1, 1'b1, 4'b0000, 16'h1111, 16'h2222);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 16'hF800);
      chk("bp_ready0", bus.req0_ready, 0);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
      step();
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    bus.rsp_ready = 1'b1;
    step();
    step();

    // Round-robin from a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    rec = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 4'b0000, 16'($urandom), 16'($urandom));
      step();
    end
    rec = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    chk("rr_grants", (gq.size() >= 4), 1);
    chk("rr_rsps", (iq.size() >= 4), 1);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) chk("rr_grant", gq[k], k % 2);
      if (k < iq.size()) chk("rr_rsp_id", iq[k], k % 2);
    end
    n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end

    // Reset during divide after eight iterations.
    drive(1'b1, 1'b0, 4'b0011, 16'hFFFF, 16'h0003);
    step();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) step();
    chk("div_midway_busy", bus.busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      step();
    end
    chk("abort_no_rsp", seen, 0);

    // Randomized traffic including resets, backpressure and input churn while busy.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ry;
      ry = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      bus.req0_valid = 1'($urandom);
      bus.req1_valid = 1'($urandom);
      bus.req0_op    = 4'($urandom);
      bus.req1_op    = 4'($urandom);
      bus.req0_x     = 16'($urandom);
      bus.req1_x     = 16'($urandom);
      bus.req0_y     = ry;
      bus.req1_y     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      bus.rsp_ready  = ($urandom_range(0, 9) < 7);
      reset          = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
